stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
// Run-time controller for the stopwatch datapath. Owns the MM:SS BCD time registers.
// Sequences count, pause and adjust modes from raw board inputs, and drives the
// digit/sel/adjust inputs of the 7-segment display multiplexer.
// Timing comes from single-cycle tick enables generated by the clock-divider block.
// PARAMETERS
// DEBOUNCE_CYCLES  1_000_000  stable-level cycles required before btn_pause is accepted (sim: 4)
// MAX_MIN          59         highest minute value before wrap to 00
// PORTS
// clk            in   1  system clock; all logic is on the rising edge
// reset          in   1  asynchronous, active-high reset
// tick_1hz       in   1  one-clk-wide enable, 1 Hz; advances the count in RUN
// tick_2hz       in   1  one-clk-wide enable, 2 Hz; advances the selected field in ADJUST
// btn_pause      in   1  raw pushbutton, asynchronous, bouncy
// sw_adj         in   1  raw slide switch; 1 = adjust mode
// sw_sel         in   1  raw slide switch; 1 = seconds field selected, 0 = minutes field
// minutes_tens   out  4  BCD 0..5
// minutes_units  out  4  BCD 0..9
// seconds_tens   out  4  BCD 0..5
// seconds_units  out  4  BCD 0..9
// adjust         out  1  1 while state==ADJUST (display blanks the selected pair)
// sel            out  1  synchronized sw_sel
// running        out  1  1 while state==RUN
// BEHAVIOUR
// - Reset: all digits 0, state RUN, ret_state RUN. Outputs: adjust=0, sel=0, running=1.
//   All synchronizer and debounce flops clear.
// - sw_adj and sw_sel pass through 2-flop synchronizers; switch changes take effect 2 clks later.
// - btn_pause: 2-flop sync, then counter. The level is accepted after DEBOUNCE_CYCLES
//   consecutive equal samples; any change restarts the count.
//   A 0->1 accepted transition emits pause_p for exactly 1 clk. No repeat while held.
// - States: RUN, PAUSED, ADJUST. Transitions are evaluated once per clk:
//   RUN    : pause_p -> PAUSED; adj_s=1 -> ADJUST with ret_state=RUN (adj_s has priority).
//   PAUSED : pause_p -> RUN; adj_s=1 -> ADJUST with ret_state=PAUSED (adj_s has priority).
//   ADJUST : adj_s=0 -> ret_state; pause_p toggles ret_state (RUN<->PAUSED) and stays in ADJUST.
// - RUN counting: on tick_1hz, MM:SS += 1 second. Carry chain: su 9->0 increments st;
//   st 5 with su 9 ->00 increments minutes; mu 9->0 increments mt.
//   At MAX_MIN:59 the count goes to 00:00 (full wrap, no flag).
// - ADJUST: on tick_2hz, sel=1 increments the seconds pair; sel=0 increments the minutes pair.
//   Each increments by 1 modulo 60 (59->00), with no carry into the other pair.
//   tick_1hz is ignored in ADJUST.
// - PAUSED: digits hold; both ticks are ignored.
// - Simultaneous events in one clk: the state update and the digit update both use the
//   pre-edge state. Example: in RUN with tick_1hz and pause_p together, the count advances
//   once and the next state is PAUSED.
// - Latency: a digit update is visible 1 clk after the tick; state outputs change 1 clk
//   after the triggering condition.
// - Digit registers never hold non-BCD values. Illegal encodings, which can only come from
//   SEU, decode as 0 on the next increment.
// - Reset mid-count or mid-adjust returns to 00:00 RUN immediately (asynchronous).
// STRUCTURE
// - Package stopwatch_pkg: state enum {RUN, PAUSED, ADJUST}, BCD limit constants
//   (SEC_TENS_MAX=5, UNITS_MAX=9), and the increment-mod-60 function returning
//   {tens,units,carry}. The function is shared with the clock-divider testbench model.
// - One sub-module, button_conditioner (sync, debounce, rising-edge pulse; DEBOUNCE_CYCLES param).
//   It is instanced once for btn_pause. The switches use plain synchronizers inline.
// - Top level: FSM, ret_state flop, 4 BCD digit registers, and increment logic.
// TESTING (DEBOUNCE_CYCLES=4, ticks driven directly by the bench)
// 1. Reset, then 65 tick_1hz pulses -> 01:05, running=1, adjust=0.
// 2. Preload 59:59 by adjust, RUN, one tick_1hz -> 00:00. Check 09:59 -> 10:00 and 00:59 -> 01:00.
// 3. Bounce btn_pause 1-0-1 with 2-clk gaps, then hold for 6 clks -> exactly one pause_p,
//    state PAUSED. 10 tick_1hz pulses cause no digit change.
// 4. sw_adj=1, sw_sel=1 at 00:58, 3 tick_2hz -> 00:01 with minutes unchanged and adjust=1.
//    sw_sel=0, 2 tick_2hz -> 02:01.
// 5. In ADJUST with ret_state=PAUSED, press pause and drop sw_adj -> state RUN, running=1.
// 6. Assert reset asynchronously mid-ADJUST at 12:34 -> digits 0 and state RUN before the
//    next clk edge; release, and the count resumes from 00:00.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and BCD helpers for the stopwatch controller and its models.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_e;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] UNITS_MAX    = 4'd9;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_pair_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
        logic       carry;
    } bcd_inc_t;

    // A digit outside its legal range can only come from an upset; it is read as 0.
    function automatic bcd_pair_t inc_bcd_pair(input logic [3:0] tens,
                                               input logic [3:0] units,
                                               input logic [3:0] tens_max,
                                               input logic [3:0] units_max);
        bcd_pair_t  r;
        logic [3:0] t;
        logic [3:0] u;
        t = (tens > tens_max) ? 4'd0 : tens;
        u = (units > UNITS_MAX) ? 4'd0 : units;
        if (t == tens_max && u == units_max) begin
            r.tens  = 4'd0;
            r.units = 4'd0;
        end else if (u == UNITS_MAX) begin
            r.tens  = t + 4'd1;
            r.units = 4'd0;
        end else begin
            r.tens  = t;
            r.units = u + 4'd1;
        end
        return r;
    endfunction

    // An increment only lands on 00 when it wraps, so that is the carry.
    function automatic bcd_inc_t inc_mod60(input logic [3:0] tens, input logic [3:0] units);
        bcd_pair_t p;
        bcd_inc_t  r;
        p       = inc_bcd_pair(tens, units, SEC_TENS_MAX, UNITS_MAX);
        r.tens  = p.tens;
        r.units = p.units;
        r.carry = (p.tens == 4'd0) && (p.units == 4'd0);
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_button_conditioner.sv
// Pushbutton conditioner: 2-flop synchronizer, level debounce and a one-clk
// pulse on each accepted press.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             cand_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic             sample;
    logic             accept;

    assign sample = sync_q[1];

    // cnt reaching zero means the last DEBOUNCE_CYCLES samples all agreed.
    always_comb begin
        cnt_d = cnt_q;
        if (sample != cand_q) begin
            cnt_d = CNT_RELOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        accept  = (cnt_d == '0);
        level_d = accept ? sample : level_q;
        pulse_d = accept & sample & ~level_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b00;
            cand_q  <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cand_q  <= sample;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-time controller: owns the MM:SS BCD registers and sequences
// RUN / PAUSED / ADJUST from synchronized board inputs.
//
// state     | meaning
// ST_RUN    | counting on tick_1hz
// ST_PAUSED | digits frozen, ticks ignored
// ST_ADJUST | tick_2hz bumps the selected pair; ret_q holds the state to go back to
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MAX_MIN         = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz_i,
    input  logic       tick_2hz_i,
    input  logic       btn_pause_i,
    input  logic       sw_adj_i,
    input  logic       sw_sel_i,
    output logic [3:0] minutes_tens_o,
    output logic [3:0] minutes_units_o,
    output logic [3:0] seconds_tens_o,
    output logic [3:0] seconds_units_o,
    output logic       adjust_o,
    output logic       sel_o,
    output logic       running_o
);

    localparam logic [3:0] MIN_TENS_MAX  = 4'(MAX_MIN / 10);
    localparam logic [3:0] MIN_UNITS_MAX = 4'(MAX_MIN % 10);

    logic [1:0] adj_sync_q;
    logic [1:0] sel_sync_q;
    logic       adj_s;
    logic       sel_s;
    logic       pause_p;

    state_e     state_q, state_d;
    state_e     ret_q, ret_d;

    logic [3:0] mt_q, mu_q, st_q, su_q;
    logic [3:0] mt_d, mu_d, st_d, su_d;
    bcd_inc_t   sec_inc;
    bcd_pair_t  min_inc;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_pause (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (btn_pause_i),
        .pulse_o(pause_p)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adj_sync_q <= 2'b00;
            sel_sync_q <= 2'b00;
        end else begin
            adj_sync_q <= {adj_sync_q[0], sw_adj_i};
            sel_sync_q <= {sel_sync_q[0], sw_sel_i};
        end
    end

    assign adj_s = adj_sync_q[1];
    assign sel_s = sel_sync_q[1];

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        case (state_q)
            ST_RUN: begin
                if (adj_s) begin
                    state_d = ST_ADJUST;
                    ret_d   = ST_RUN;
                end else if (pause_p) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (adj_s) begin
                    state_d = ST_ADJUST;
                    ret_d   = ST_PAUSED;
                end else if (pause_p) begin
                    state_d = ST_RUN;
                end
            end
            ST_ADJUST: begin
                // A press on the same clk as leaving adjust still counts.
                if (pause_p) begin
                    ret_d = (ret_q == ST_RUN) ? ST_PAUSED : ST_RUN;
                end
                if (!adj_s) begin
                    state_d = ret_d;
                end
            end
            default: begin
                state_d = ST_RUN;
                ret_d   = ST_RUN;
            end
        endcase
    end

    assign sec_inc = inc_mod60(st_q, su_q);
    assign min_inc = inc_bcd_pair(mt_q, mu_q, MIN_TENS_MAX, MIN_UNITS_MAX);

    always_comb begin
        mt_d = mt_q;
        mu_d = mu_q;
        st_d = st_q;
        su_d = su_q;
        if (state_q == ST_RUN && tick_1hz_i) begin
            st_d = sec_inc.tens;
            su_d = sec_inc.units;
            if (sec_inc.carry) begin
                mt_d = min_inc.tens;
                mu_d = min_inc.units;
            end
        end else if (state_q == ST_ADJUST && tick_2hz_i) begin
            if (sel_s) begin
                st_d = sec_inc.tens;
                su_d = sec_inc.units;
            end else begin
                mt_d = min_inc.tens;
                mu_d = min_inc.units;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            ret_q   <= ST_RUN;
            mt_q    <= 4'd0;
            mu_q    <= 4'd0;
            st_q    <= 4'd0;
            su_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            mt_q    <= mt_d;
            mu_q    <= mu_d;
            st_q    <= st_d;
            su_q    <= su_d;
        end
    end

    assign minutes_tens_o  = mt_q;
    assign minutes_units_o = mu_q;
    assign seconds_tens_o  = st_q;
    assign seconds_units_o = su_q;
    assign adjust_o        = (state_q == ST_ADJUST);
    assign running_o       = (state_q == ST_RUN);
    assign sel_o           = sel_s;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: an integer-seconds reference model predicts
// every clk; a monitor compares each negedge; directed checks use BCD constants.
module tb_stopwatch_ctrl;

    localparam int N_DEB    = 4;
    localparam int M_RUN    = 0;
    localparam int M_PAUSED = 1;
    localparam int M_ADJUST = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       tick_2hz = 1'b0;
    logic       btn_pause = 1'b0;
    logic       sw_adj = 1'b0;
    logic       sw_sel = 1'b0;
    logic [3:0] mt, mu, st, su;
    logic       adjust, sel, running;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(N_DEB),
        .MAX_MIN        (59)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tick_1hz_i     (tick_1hz),
        .tick_2hz_i     (tick_2hz),
        .btn_pause_i    (btn_pause),
        .sw_adj_i       (sw_adj),
        .sw_sel_i       (sw_sel),
        .minutes_tens_o (mt),
        .minutes_units_o(mu),
        .seconds_tens_o (st),
        .seconds_units_o(su),
        .adjust_o       (adjust),
        .sel_o          (sel),
        .running_o      (running)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: whole minutes/seconds as integers plus raw input history.
    int  m_min = 0, m_sec = 0, m_state = M_RUN, m_ret = M_RUN;
    bit  m_level = 1'b0, m_pulse = 1'b0, m_sel_out = 1'b0;
    bit  h_adj[$], h_sel[$], h_btn[$];
    logic [18:0] exp_q[$];

    function automatic bit past(input bit q[$], input int d);
        if (q.size() > d) return q[q.size() - 1 - d];
        return 1'b0;
    endfunction

    function automatic logic [18:0] pack_exp(input int mins, input int secs,
                                             input bit a, input bit s, input bit r);
        return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10), a, s, r};
    endfunction

    task automatic model_step();
        bit adj_s, sel_s, p, v, stable;
        int t;
        if (reset) begin
            h_adj.delete(); h_sel.delete(); h_btn.delete();
            m_min = 0; m_sec = 0; m_state = M_RUN; m_ret = M_RUN;
            m_level = 1'b0; m_pulse = 1'b0; m_sel_out = 1'b0;
            return;
        end
        h_adj.push_back(sw_adj);
        h_sel.push_back(sw_sel);
        h_btn.push_back(btn_pause);
        // Switch/button values seen by the logic are two clks old.
        adj_s = past(h_adj, 2);
        sel_s = past(h_sel, 2);
        p     = m_pulse;
        v     = past(h_btn, 2);
        stable = 1'b1;
        for (int i = 3; i <= N_DEB + 1; i++) if (past(h_btn, i) != v) stable = 1'b0;
        m_pulse = stable && v && !m_level;
        if (stable) m_level = v;
        if (m_state == M_RUN && tick_1hz) begin
            t = (m_min * 60 + m_sec + 1) % 3600;
            m_min = t / 60;
            m_sec = t % 60;
        end else if (m_state == M_ADJUST && tick_2hz) begin
            if (sel_s) m_sec = (m_sec + 1) % 60;
            else       m_min = (m_min + 1) % 60;
        end
        case (m_state)
            M_RUN: begin
                if (adj_s) begin m_state = M_ADJUST; m_ret = M_RUN; end
                else if (p) m_state = M_PAUSED;
            end
            M_PAUSED: begin
                if (adj_s) begin m_state = M_ADJUST; m_ret = M_PAUSED; end
                else if (p) m_state = M_RUN;
            end
            default: begin
                if (p) m_ret = (m_ret == M_RUN) ? M_PAUSED : M_RUN;
                if (!adj_s) m_state = m_ret;
            end
        endcase
        m_sel_out = past(h_sel, 1);
        while (h_adj.size() > N_DEB + 4) begin
            void'(h_adj.pop_front()); void'(h_sel.pop_front()); void'(h_btn.pop_front());
        end
    endtask

    task automatic clk_cycle();
        logic [18:0] e;
        model_step();
        e = pack_exp(m_min, m_sec, m_state == M_ADJUST, m_sel_out, m_state == M_RUN);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        cyc++;
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
    endtask

    task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic enter_adjust();
        sw_adj = 1'b1;
        repeat (4) clk_cycle();
    endtask

    task automatic exit_adjust();
        sw_adj = 1'b0;
        repeat (4) clk_cycle();
    endtask

    task automatic adjust_to(input int mins, input int secs);
        sw_sel = 1'b0;
        repeat (3) clk_cycle();
        repeat ((mins - m_min + 60) % 60) begin tick_2hz = 1'b1; clk_cycle(); end
        sw_sel = 1'b1;
        repeat (3) clk_cycle();
        repeat ((secs - m_sec + 60) % 60) begin tick_2hz = 1'b1; clk_cycle(); end
    endtask

    task automatic async_reset(input string name);
        @(negedge clk);
        #2;
        reset  = 1'b1;
        sw_adj = 1'b0;
        #1;
        check_val({name, " digits"}, {mt, mu, st, su}, 16'h0000);
        check_val({name, " flags"}, {13'd0, adjust, sel, running}, 16'h0001);
        repeat (2) clk_cycle();
        reset = 1'b0;
    endtask

    // Monitor: pops one prediction per clk once the driver has produced it.
    initial begin
        logic [18:0] e, g;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {mt, mu, st, su, adjust, sel, running};
                n_cmp++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL scoreboard cyc=%0d got %h%h:%h%h adj=%b sel=%b run=%b expected %h%h:%h%h adj=%b sel=%b run=%b",
                             cyc, g[18:15], g[14:11], g[10:7], g[6:3], g[2], g[1], g[0],
                             e[18:15], e[14:11], e[10:7], e[6:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check_val("reset digits", {mt, mu, st, su}, 16'h0000);
        check_val("reset flags", {13'd0, adjust, sel, running}, 16'h0001);
        repeat (2) clk_cycle();
        reset = 1'b0;
        repeat (3) clk_cycle();

        // Plain counting with carry from seconds into minutes.
        repeat (65) begin tick_1hz = 1'b1; clk_cycle(); clk_cycle(); end
        check_val("count 65s", {mt, mu, st, su}, 16'h0105);
        check_val("count flags", {14'd0, adjust, running}, 16'h0001);

        // Full wrap and decade boundaries.
        enter_adjust();
        check_val("adjust entered", {14'd0, adjust, running}, 16'h0002);
        adjust_to(59, 59);
        exit_adjust();
        check_val("preload 59:59", {mt, mu, st, su}, 16'h5959);
        tick_1hz = 1'b1; clk_cycle();
        check_val("wrap 59:59", {mt, mu, st, su}, 16'h0000);
        enter_adjust(); adjust_to(9, 59); exit_adjust();
        tick_1hz = 1'b1; clk_cycle();
        check_val("carry 09:59", {mt, mu, st, su}, 16'h1000);
        enter_adjust(); adjust_to(0, 59); exit_adjust();
        tick_1hz = 1'b1; clk_cycle();
        check_val("carry 00:59", {mt, mu, st, su}, 16'h0100);

        // Bouncy press: exactly one accepted pause.
        btn_pause = 1'b1; repeat (2) clk_cycle();
        btn_pause = 1'b0; repeat (2) clk_cycle();
        btn_pause = 1'b1; repeat (10) clk_cycle();
        check_val("paused flags", {14'd0, adjust, running}, 16'h0000);
        repeat (10) begin tick_1hz = 1'b1; clk_cycle(); end
        check_val("paused hold", {mt, mu, st, su}, 16'h0100);
        btn_pause = 1'b0; repeat (8) clk_cycle();
        check_val("release no pulse", {14'd0, adjust, running}, 16'h0000);

        // Adjust from PAUSED: per-pair modulo-60 with no cross carry.
        enter_adjust(); adjust_to(0, 58);
        check_val("preload 00:58", {mt, mu, st, su}, 16'h0058);
        repeat (3) begin tick_2hz = 1'b1; clk_cycle(); end
        check_val("adj sec wrap", {mt, mu, st, su}, 16'h0001);
        check_val("adj flags", {13'd0, adjust, sel, running}, 16'h0006);
        sw_sel = 1'b0; repeat (3) clk_cycle();
        repeat (2) begin tick_2hz = 1'b1; clk_cycle(); end
        check_val("adj minutes", {mt, mu, st, su}, 16'h0201);
        repeat (3) begin tick_1hz = 1'b1; clk_cycle(); end
        check_val("adj ignores 1hz", {mt, mu, st, su}, 16'h0201);

        // Pause press inside ADJUST flips the return state to RUN.
        btn_pause = 1'b1; repeat (8) clk_cycle();
        btn_pause = 1'b0; repeat (8) clk_cycle();
        check_val("still adjust", {14'd0, adjust, running}, 16'h0002);
        exit_adjust();
        check_val("return run", {14'd0, adjust, running}, 16'h0001);
        tick_1hz = 1'b1; clk_cycle();
        check_val("run resumes", {mt, mu, st, su}, 16'h0202);

        // Asynchronous reset mid-adjust.
        enter_adjust(); adjust_to(12, 34);
        check_val("preload 12:34", {mt, mu, st, su}, 16'h1234);
        async_reset("async reset");
        repeat (3) clk_cycle();
        repeat (3) begin tick_1hz = 1'b1; clk_cycle(); end
        check_val("count after reset", {mt, mu, st, su}, 16'h0003);
        check_val("run after reset", {14'd0, adjust, running}, 16'h0001);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            tick_1hz = ($urandom_range(0, 2) == 0);
            tick_2hz = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0)  btn_pause = ~btn_pause;
            if ($urandom_range(0, 39) == 0) sw_adj    = ~sw_adj;
            if ($urandom_range(0, 9) == 0)  sw_sel    = ~sw_sel;
            if (i == 900) async_reset("random reset");
            clk_cycle();
        end

        repeat (2) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
